// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider serving the EX-stage
// divide handshake. It produces {remainder, quotient} for DIV/DIVU and holds
// the pipeline through stall until the result is ready or the op is annulled.
// Optional feature macro: DIVIDER_EARLY_EXIT_EN. When it is defined, an
// operation whose dividend magnitude is below the divisor magnitude completes
// straight away. Results are identical whether or not it is defined.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_ZERO = 2'd1,
        S_ON       = 2'd2,
        S_END      = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_qsign;
    logic               r_rsign;
    logic [2*WIDTH-1:0] r_result;

    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_accept;
    logic               w_early;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Two's complement negation when n is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                   input logic n);
        return n ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // Operand signs only matter for DIV; magnitudes feed the unsigned core.
    assign w_s1   = signed_div & opdata1[WIDTH-1];
    assign w_s2   = signed_div & opdata2[WIDTH-1];
    assign w_mag1 = negate_if(opdata1, w_s1);
    assign w_mag2 = negate_if(opdata2, w_s2);

    assign w_accept = (r_state == S_IDLE) & start & ~annul;

`ifdef DIVIDER_EARLY_EXIT_EN
    assign w_early = (w_mag1 < w_mag2);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step. The shifted partial remainder is WIDTH+1 bits wide;
    // a set top bit means it already exceeds any divisor, and the low WIDTH
    // bits of the difference are exact because the true result is < divisor.
    assign w_shifted  = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_ge       = r_rem[WIDTH-1] | (w_shifted >= r_dvs);
    assign w_rem_next = w_ge ? (w_shifted - r_dvs) : w_shifted;
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    // Sign fixups: quotient takes s1^s2, remainder follows the dividend.
    assign w_quo_fix = negate_if(r_quo, r_qsign);
    assign w_rem_fix = negate_if(r_rem, r_rsign);

    // Completion is visible in the END cycle itself; the held copy in
    // r_result takes over from the following cycle.
    assign ready  = (r_state == S_END) & ~annul;
    assign result = ready ? {w_rem_fix, w_quo_fix} : r_result;
    assign stall  = w_accept | (r_state == S_DIV_ZERO) | (r_state == S_ON)
                  | ((r_state == S_END) & annul);

    // Divider control FSM together with the operand/remainder datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (opdata2 == '0) begin
                            // Divide by zero yields a fixed all-zero result.
                            r_state <= S_DIV_ZERO;
                            r_rem   <= '0;
                            r_quo   <= '0;
                            r_qsign <= 1'b0;
                            r_rsign <= 1'b0;
                        end else if (w_early) begin
                            r_state <= S_END;
                            r_rem   <= w_mag1;
                            r_quo   <= '0;
                            r_qsign <= w_s1 ^ w_s2;
                            r_rsign <= w_s1;
                        end else begin
                            r_state <= S_ON;
                            r_rem   <= '0;
                            r_quo   <= w_mag1;
                            r_dvs   <= w_mag2;
                            r_qsign <= w_s1 ^ w_s2;
                            r_rsign <= w_s1;
                        end
                    end
                end
                S_DIV_ZERO: begin
                    r_state <= S_END;
                end
                S_ON: begin
                    if (annul | ~start) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) begin
                            r_state <= S_END;
                        end
                    end
                end
                S_END: begin
                    if (!annul) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed DIV/DIVU vectors with literal expected
// results, plus a latency/arithmetic reference model compared every cycle.
module tb_iter_divider;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          signed_div;
    logic [W-1:0]  opdata1;
    logic [W-1:0]  opdata2;
    logic          start;
    logic          annul;
    logic [2*W-1:0] result;
    logic          ready;
    logic          stall;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference quotient/remainder from plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Cycles from acceptance to the ready pulse.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        if (b == 32'd0) return 2;
`ifdef DIVIDER_EARLY_EXIT_EN
        if (mag(a, s) < mag(b, s)) return 1;
`endif
        return W + 1;
    endfunction

    // Reference model and per-cycle compare of ready, stall and result.
    initial begin
        logic        m_busy;
        logic        m_div0;
        int          m_done;
        logic [63:0] m_pend;
        logic [63:0] m_last;
        logic        e_rdy;
        logic        e_stl;
        logic [63:0] e_res;
        m_busy = 1'b0;
        m_div0 = 1'b0;
        m_done = 0;
        m_pend = 64'd0;
        m_last = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 1'b0;
                m_last = 64'd0;
                e_rdy  = 1'b0;
                e_stl  = start & ~annul;
                e_res  = 64'd0;
            end else if (m_busy) begin
                e_rdy = 1'b0;
                e_stl = 1'b1;
                e_res = m_last;
                if (cyc == m_done) begin
                    e_rdy  = ~annul;
                    e_stl  = annul;
                    m_busy = 1'b0;
                    if (!annul) begin
                        m_last = m_pend;
                        e_res  = m_pend;
                    end
                end else if (!m_div0 && (annul || !start)) begin
                    m_busy = 1'b0;
                end
            end else begin
                e_rdy = 1'b0;
                e_res = m_last;
                e_stl = start & ~annul;
                if (start && !annul) begin
                    m_busy = 1'b1;
                    m_div0 = (opdata2 == 32'd0);
                    m_done = cyc + ref_lat(opdata1, opdata2, signed_div);
                    m_pend = ref_div(opdata1, opdata2, signed_div);
                end
            end
            checks++;
            if (ready !== e_rdy) begin
                failures++;
                $display("FAIL model_ready cyc=%0d got=%b exp=%b", cyc, ready, e_rdy);
            end
            checks++;
            if (stall !== e_stl) begin
                failures++;
                $display("FAIL model_stall cyc=%0d got=%b exp=%b", cyc, stall, e_stl);
            end
            checks++;
            if (result !== e_res) begin
                failures++;
                $display("FAIL model_result cyc=%0d got=%h exp=%h", cyc, result, e_res);
            end
        end
    end

    task automatic check_val(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue one operation, hold start until ready, check latency and result.
    task automatic do_op(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         input logic [63:0] lit, input int lat);
        int t0;
        bit got;
        @(posedge clk);
        #1;
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        annul      = 1'b0;
        t0         = cyc;
        got        = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
            else if (cyc == t0 + 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_latency got=timeout exp=%0d", name, lat);
        end else if (cyc - t0 != lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, cyc - t0, lat);
        end
        check_val({name, "_result"}, result, lit);
    endtask

    initial begin
        int lat_e;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        #2 rst = 1'b0;
        #1;
        check_val("reset_result", result, 64'd0);
        check_val("reset_ready", {63'd0, ready}, 64'd0);
        check_val("reset_stall", {63'd0, stall}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_op("divu_7_2",   32'd7,          32'd2,          1'b0, 64'h00000001_00000003, 33);
        do_op("div_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_op("div_7_m2",   32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33);
        do_op("div_wrap",   32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33);
        do_op("divu_max_1", 32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF, 33);
        do_op("divu_5_0",   32'd5,          32'd0,          1'b0, 64'd0,                 2);
        do_op("divu_9_4",   32'd9,          32'd4,          1'b0, 64'h00000001_00000002, 33);

        // Annul in the middle of DIVU 100/3.
        @(posedge clk);
        #1;
        opdata1 = 32'd100; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        #1;
        check_val("annul_stall", {63'd0, stall}, 64'd0);
        check_val("annul_result", result, 64'h00000001_00000002);
        repeat (40) @(posedge clk);
        #1;
        check_val("annul_result_held", result, 64'h00000001_00000002);

        // Asynchronous reset in the middle of DIVU 100/3.
        @(posedge clk);
        #1;
        opdata1 = 32'd100; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check_val("areset_result", result, 64'd0);
        check_val("areset_ready", {63'd0, ready}, 64'd0);
        check_val("areset_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(posedge clk);

`ifdef DIVIDER_EARLY_EXIT_EN
        lat_e = 1;
`else
        lat_e = 33;
`endif
        do_op("div_m3_7", 32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFD_00000000, lat_e);
        do_op("divu_100_3", 32'd100, 32'd3, 1'b0, 64'h00000001_00000021, 33);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
